// File: rtl/iter_logic_shift_unit_if.sv
// iter_logic_shift_unit_if: request/result handshake bundle for the iterative logic/shift unit.
interface iter_logic_shift_unit_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic [2:0]       LogicFunc;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] LogicUnitOut;
    logic             zero;
    logic             busy;
    modport master (
        output in_valid, X, Y, LogicFunc, out_ready,
        input  in_ready, out_valid, LogicUnitOut, zero, busy
    );
    modport slave (
        input  in_valid, X, Y, LogicFunc, out_ready,
        output in_ready, out_valid, LogicUnitOut, zero, busy
    );
endinterface

// File: rtl/iter_logic_shift_unit.sv
// iter_logic_shift_unit: single-cycle logic ops, shifts/rotates applied SHIFT_STEP bits per cycle.
module iter_logic_shift_unit #(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 4
) (
    input logic                     clk,
    input logic                     rst_n,
    iter_logic_shift_unit_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] Y_W  = WIDTH'(WIDTH);
    localparam logic [CNT_W-1:0] C_W  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] C_ST = CNT_W'(SHIFT_STEP);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CNT_W-1:0] rem_q, rem_d;

    logic             is_rot, is_logic;
    logic [CNT_W-1:0] eff, k;
    logic [WIDTH-1:0] logic_res, sra_res, step_res;

    assign is_rot    = bus.LogicFunc[2] & bus.LogicFunc[0];
    assign is_logic  = bus.LogicFunc inside {3'b000, 3'b001, 3'b011};
    assign eff       = is_rot ? CNT_W'(bus.Y % Y_W) : (bus.Y >= Y_W ? C_W : CNT_W'(bus.Y));
    assign logic_res = bus.LogicFunc == 3'b000 ? bus.X & bus.Y :
                       bus.LogicFunc == 3'b001 ? bus.X ^ bus.Y : bus.X | bus.Y;
    assign k         = rem_q < C_ST ? rem_q : C_ST;
    // Kept separate so the arithmetic shift is evaluated in a signed context
    assign sra_res   = $signed(res_q) >>> k;
    assign step_res  = op_q == 3'b010 ? res_q << k :
                       op_q == 3'b110 ? res_q >> k :
                       op_q == 3'b100 ? sra_res :
                       op_q == 3'b101 ? (res_q << k) | (res_q >> (C_W - k)) :
                                        (res_q >> k) | (res_q << (C_W - k));

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        res_d   = res_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                op_d    = bus.LogicFunc;
                res_d   = is_logic ? logic_res : bus.X;
                rem_d   = is_logic ? '0 : eff;
                state_d = (is_logic || eff == '0) ? DONE : SHIFT;
            end
            SHIFT: begin
                res_d   = step_res;
                rem_d   = rem_q - k;
                state_d = rem_d == '0 ? DONE : SHIFT;
            end
            DONE:    state_d = bus.out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            res_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            res_q   <= res_d;
            rem_q   <= rem_d;
        end
    end

    assign bus.in_ready     = state_q == IDLE;
    assign bus.out_valid    = state_q == DONE;
    assign bus.busy         = state_q != IDLE;
    assign bus.LogicUnitOut = res_q;
    assign bus.zero         = res_q == '0;
endmodule

// File: tb/tb_iter_logic_shift_unit.sv
// tb_iter_logic_shift_unit: scoreboard bench for the 32/4 unit plus two 8-bit parameter points.
module tb_iter_logic_shift_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic [31:0] exp_q[$];
    int          lat_q[$];
    logic [7:0]  exp8_q[$];

    iter_logic_shift_unit_if #(.WIDTH(32)) if0 ();
    iter_logic_shift_unit_if #(.WIDTH(8))  if1 ();
    iter_logic_shift_unit_if #(.WIDTH(8))  if2 ();

    iter_logic_shift_unit #(.WIDTH(32), .SHIFT_STEP(4)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    iter_logic_shift_unit #(.WIDTH(8),  .SHIFT_STEP(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    iter_logic_shift_unit #(.WIDTH(8),  .SHIFT_STEP(8)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] model32(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] t;
        int s, r;
        s = (y > 32) ? 32 : int'(y);
        r = int'(y % 32);
        case (f)
            3'b000: t = {32'h0, x & y};
            3'b001: t = {32'h0, x ^ y};
            3'b011: t = {32'h0, x | y};
            3'b010: t = {32'h0, x} << s;
            3'b110: t = {32'h0, x} >> s;
            3'b100: t = {{32{x[31]}}, x} >> s;
            3'b101: begin t = {x, x} << r; t = {32'h0, t[63:32]}; end
            default: t = {x, x} >> r;
        endcase
        return t[31:0];
    endfunction

    function automatic int lat32(input logic [2:0] f, input logic [31:0] y);
        int e;
        if (f inside {3'b000, 3'b001, 3'b011}) return 1;
        e = (f[2] & f[0]) ? int'(y % 32) : ((y > 32) ? 32 : int'(y));
        return e == 0 ? 1 : 1 + (e + 3) / 4;
    endfunction

    task automatic do_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp, input string name, input bit scr);
        int acc, el;
        logic [31:0] e;
        exp_q.push_back(exp);
        lat_q.push_back(lat32(f, y));
        @(negedge clk);
        if0.in_valid = 1'b1; if0.X = x; if0.Y = y; if0.LogicFunc = f; if0.out_ready = 1'b1;
        for (int i = 0; i < 50 && !if0.in_ready; i++) @(negedge clk);
        total++;
        if (if0.in_ready !== 1'b1) begin bad++; $display("FAIL %s accept: in_ready=%b want 1", name, if0.in_ready); end
        acc = cyc;
        @(posedge clk);
        #1 if0.in_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 50 && !if0.out_valid; i++) begin
            if (scr) begin if0.X = $urandom; if0.Y = $urandom; if0.LogicFunc = 3'($urandom); end
            @(negedge clk);
        end
        e  = exp_q.pop_front();
        el = lat_q.pop_front();
        total++;
        if (if0.out_valid !== 1'b1) begin bad++; $display("FAIL %s timeout: out_valid=%b want 1", name, if0.out_valid); end
        total++;
        if (if0.LogicUnitOut !== e) begin bad++; $display("FAIL %s result: got %h want %h", name, if0.LogicUnitOut, e); end
        total++;
        if (if0.zero !== (e == 32'h0)) begin bad++; $display("FAIL %s zero: got %b want %b", name, if0.zero, e == 32'h0); end
        total++;
        if (cyc - acc !== el) begin bad++; $display("FAIL %s latency: got %0d want %0d", name, cyc - acc, el); end
        @(posedge clk);
    endtask

    task automatic test_reset;
        #1;
        total++;
        if ({if0.in_ready, if0.out_valid, if0.busy, if0.zero} !== 4'b1001 || if0.LogicUnitOut !== 32'h0) begin
            bad++;
            $display("FAIL reset: rdy/vld/busy/zero=%b out=%h want 1001 00000000",
                     {if0.in_ready, if0.out_valid, if0.busy, if0.zero}, if0.LogicUnitOut);
        end
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_logic;
        do_op(3'b000, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, "and", 0);
        do_op(3'b001, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, "xor", 0);
        do_op(3'b011, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFFF0_FFFF, "or", 0);
    endtask

    task automatic test_shift;
        do_op(3'b100, 32'h8000_0000, 32'd5,  32'hFC00_0000, "sra5", 0);
        do_op(3'b110, 32'h8000_0000, 32'd5,  32'h0400_0000, "srl5", 0);
        do_op(3'b010, 32'h0000_0001, 32'd31, 32'h8000_0000, "sll31", 0);
        do_op(3'b010, 32'hDEAD_BEEF, 32'd0,  32'hDEAD_BEEF, "sll0", 0);
    endtask

    task automatic test_overrange_rotate;
        do_op(3'b010, 32'hFFFF_FFFF, 32'd40,        32'h0000_0000, "sll40", 0);
        do_op(3'b100, 32'h8000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "sra_big", 0);
        do_op(3'b111, 32'h1234_5678, 32'd8,         32'h7812_3456, "ror8", 0);
        do_op(3'b101, 32'h1234_5678, 32'd40,        32'h3456_7812, "rol40", 0);
        do_op(3'b101, 32'h1234_5678, 32'd64,        32'h1234_5678, "rol64", 0);
    endtask

    task automatic test_random;
        logic [2:0] f;
        logic [31:0] x, y;
        for (int i = 0; i < 12; i++) begin
            f = 3'($urandom);
            x = $urandom;
            y = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
            do_op(f, x, y, model32(f, x, y), "random", 0);
        end
    endtask

    task automatic test_input_stability;
        do_op(3'b010, 32'h0000_0001, 32'd31, 32'h8000_0000, "stable_sll", 1);
        do_op(3'b111, 32'hA5A5_0F0F, 32'd13, model32(3'b111, 32'hA5A5_0F0F, 32'd13), "stable_ror", 1);
    endtask

    task automatic test_backpressure;
        logic [31:0] e;
        exp_q.push_back(32'h0400_0000);
        @(negedge clk);
        if0.in_valid = 1'b1; if0.X = 32'h8000_0000; if0.Y = 32'd5; if0.LogicFunc = 3'b110; if0.out_ready = 1'b0;
        @(posedge clk);
        #1 if0.in_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 50 && !if0.out_valid; i++) @(negedge clk);
        e = exp_q.pop_front();
        total++;
        if (if0.LogicUnitOut !== e) begin bad++; $display("FAIL bp result: got %h want %h", if0.LogicUnitOut, e); end
        if0.in_valid = 1'b1; if0.LogicFunc = 3'b000; if0.Y = 32'h0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if ({if0.out_valid, if0.in_ready, if0.zero} !== 3'b100 || if0.LogicUnitOut !== e) begin
                bad++;
                $display("FAIL bp hold %0d: vld/rdy/zero=%b out=%h want 100 %h",
                         i, {if0.out_valid, if0.in_ready, if0.zero}, if0.LogicUnitOut, e);
            end
        end
        if0.in_valid = 1'b0; if0.out_ready = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({if0.out_valid, if0.in_ready, if0.busy} !== 3'b010) begin
            bad++; $display("FAIL bp release: vld/rdy/busy=%b want 010", {if0.out_valid, if0.in_ready, if0.busy});
        end
    endtask

    task automatic test_back_to_back;
        logic [2:0]  fs[4] = '{3'b000, 3'b010, 3'b001, 3'b111};
        logic [31:0] xs[4] = '{32'h0000_00FF, 32'h0000_0003, 32'hAAAA_5555, 32'h8765_4321};
        logic [31:0] ys[4] = '{32'h0000_0F0F, 32'd9, 32'hFFFF_0000, 32'd4};
        int n_acc = 0, n_done = 0, hs = -10;
        bit acc_now;
        logic [31:0] e;
        @(negedge clk);
        if0.out_ready = 1'b1; if0.in_valid = 1'b1;
        if0.X = xs[0]; if0.Y = ys[0]; if0.LogicFunc = fs[0];
        for (int c = 0; c < 200 && n_done < 4; c++) begin
            if (if0.out_valid) begin
                e = exp_q.pop_front();
                total++;
                if (if0.LogicUnitOut !== e) begin bad++; $display("FAIL b2b result %0d: got %h want %h", n_done, if0.LogicUnitOut, e); end
                hs = cyc;
                n_done++;
            end
            acc_now = if0.in_ready && if0.in_valid;
            if (acc_now) begin
                if (n_acc > 0) begin
                    total++;
                    if (cyc !== hs + 1) begin bad++; $display("FAIL b2b gap %0d: accept cyc %0d want %0d", n_acc, cyc, hs + 1); end
                end
                exp_q.push_back(model32(fs[n_acc], xs[n_acc], ys[n_acc]));
                n_acc++;
            end
            @(posedge clk);
            #1;
            if (acc_now) begin
                if (n_acc < 4) begin if0.X = xs[n_acc]; if0.Y = ys[n_acc]; if0.LogicFunc = fs[n_acc]; end
                else if0.in_valid = 1'b0;
            end
            @(negedge clk);
        end
        total++;
        if (n_done !== 4) begin bad++; $display("FAIL b2b count: got %0d want 4", n_done); end
    endtask

    task automatic test_reset_mid;
        bit seen = 0;
        @(negedge clk);
        if0.in_valid = 1'b1; if0.X = 32'h1; if0.Y = 32'd20; if0.LogicFunc = 3'b010; if0.out_ready = 1'b1;
        @(posedge clk);
        #1 if0.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        total++;
        if (if0.busy !== 1'b1 || if0.out_valid !== 1'b0) begin
            bad++; $display("FAIL mid shifting: busy/vld=%b want 10", {if0.busy, if0.out_valid});
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({if0.in_ready, if0.out_valid, if0.busy, if0.zero} !== 4'b1001 || if0.LogicUnitOut !== 32'h0) begin
            bad++;
            $display("FAIL mid reset: rdy/vld/busy/zero=%b out=%h want 1001 00000000",
                     {if0.in_ready, if0.out_valid, if0.busy, if0.zero}, if0.LogicUnitOut);
        end
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (if0.out_valid) seen = 1;
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL mid spurious: out_valid seen=%b want 0", seen); end
        do_op(3'b000, 32'd3, 32'd5, 32'd1, "after_reset_and", 0);
    endtask

    task automatic test_sweep_s1;
        logic [2:0] fs[2] = '{3'b100, 3'b111};
        logic [7:0] xs[2] = '{8'h90, 8'h81};
        logic [7:0] ys[2] = '{8'd3, 8'd9};
        logic [7:0] es[2] = '{8'hF2, 8'hC0};
        int         ls[2] = '{4, 2};
        int acc;
        logic [7:0] e;
        for (int i = 0; i < 2; i++) begin
            exp8_q.push_back(es[i]);
            @(negedge clk);
            if1.in_valid = 1'b1; if1.X = xs[i]; if1.Y = ys[i]; if1.LogicFunc = fs[i]; if1.out_ready = 1'b1;
            acc = cyc;
            @(posedge clk);
            #1 if1.in_valid = 1'b0;
            @(negedge clk);
            for (int j = 0; j < 30 && !if1.out_valid; j++) @(negedge clk);
            e = exp8_q.pop_front();
            total++;
            if (if1.LogicUnitOut !== e) begin bad++; $display("FAIL w8s1 result %0d: got %h want %h", i, if1.LogicUnitOut, e); end
            total++;
            if (cyc - acc !== ls[i]) begin bad++; $display("FAIL w8s1 latency %0d: got %0d want %0d", i, cyc - acc, ls[i]); end
            @(posedge clk);
        end
    endtask

    task automatic test_sweep_s8;
        logic [2:0] fs[2] = '{3'b010, 3'b101};
        logic [7:0] xs[2] = '{8'h90, 8'h81};
        logic [7:0] ys[2] = '{8'd3, 8'd12};
        logic [7:0] es[2] = '{8'h80, 8'h18};
        int acc;
        logic [7:0] e;
        for (int i = 0; i < 2; i++) begin
            exp8_q.push_back(es[i]);
            @(negedge clk);
            if2.in_valid = 1'b1; if2.X = xs[i]; if2.Y = ys[i]; if2.LogicFunc = fs[i]; if2.out_ready = 1'b1;
            acc = cyc;
            @(posedge clk);
            #1 if2.in_valid = 1'b0;
            @(negedge clk);
            for (int j = 0; j < 30 && !if2.out_valid; j++) @(negedge clk);
            e = exp8_q.pop_front();
            total++;
            if (if2.LogicUnitOut !== e) begin bad++; $display("FAIL w8s8 result %0d: got %h want %h", i, if2.LogicUnitOut, e); end
            total++;
            if (cyc - acc !== 2) begin bad++; $display("FAIL w8s8 latency %0d: got %0d want 2", i, cyc - acc); end
            @(posedge clk);
        end
    endtask

    initial begin
        if0.in_valid = 1'b0; if0.X = '0; if0.Y = '0; if0.LogicFunc = '0; if0.out_ready = 1'b0;
        if1.in_valid = 1'b0; if1.X = '0; if1.Y = '0; if1.LogicFunc = '0; if1.out_ready = 1'b0;
        if2.in_valid = 1'b0; if2.X = '0; if2.Y = '0; if2.LogicFunc = '0; if2.out_ready = 1'b0;
        test_reset();
        test_logic();
        test_shift();
        test_overrange_rotate();
        test_random();
        test_input_stability();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_sweep_s1();
        test_sweep_s8();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/iter_logic_shift_unit.md
Name: iter_logic_shift_unit

Overview:
- Parametrised successor to the single-cycle combinational logic unit: WIDTH-bit logic, shift and rotate unit with valid/ready handshakes on both sides.
- Logic ops complete in one cycle. Shifts and rotates execute iteratively, SHIFT_STEP bits per cycle, which keeps the barrel logic small.
- Sits in the execute stage beside the adder. The control unit stalls on in_ready/out_valid.

Parameters:
- WIDTH, 32, operand/result width; legal range 2..64.
- SHIFT_STEP, 4, maximum bits shifted per SHIFT cycle; legal range 1..WIDTH.
- CNT_W, $clog2(WIDTH+1), width of the remaining-amount counter; derived from WIDTH, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept; high only in IDLE.
- X  in  WIDTH  operand / value to shift.
- Y  in  WIDTH  operand / shift amount.
- LogicFunc  in  3  operation select.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts result.
- LogicUnitOut  out  WIDTH  result.
- zero  out  1  LogicUnitOut == 0; qualified by out_valid.
- busy  out  1  state != IDLE.

Behaviour:
- Encoding (existing five unchanged, three new):
  - 000 AND; 001 XOR; 011 OR.
  - 010 SLL; 110 SRL; 100 SRA.
  - 101 ROL; 111 ROR.
- Shift amount:
  - SLL/SRL/SRA: eff = min(Y, WIDTH), with Y compared as unsigned over its full width.
  - ROL/ROR: eff = Y mod WIDTH.
  - Consequences: Y >= WIDTH gives 0 for SLL/SRL and WIDTH copies of X[WIDTH-1] for SRA. Rotate by a multiple of WIDTH returns X unchanged.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at an edge, latch op and X into the result register and load rem=eff.
  - Logic op: load X op Y, go DONE.
  - Shift/rotate with eff==0: go DONE, result = X.
  - Otherwise go SHIFT.
- SHIFT:
  - Each edge applies k = min(SHIFT_STEP, rem) bits of the latched op to the result register, then rem -= k.
  - When the new rem == 0, go DONE.
  - SRA fills with the original sign bit, which is preserved because the register MSB keeps it.
- DONE:
  - out_valid=1; LogicUnitOut and zero are stable.
  - On out_ready at an edge, go IDLE.
  - No new request is accepted in the same cycle as the result handshake; in_ready rises the following cycle.
- Latency, counted in edges from the accepting edge to out_valid high:
  - Logic ops and eff==0: 1.
  - Shifts/rotates: 1 + ceil(eff/SHIFT_STEP).
  - WIDTH=32, STEP=4 worst case: 9.
- Input stability: X, Y and LogicFunc are sampled only at the accepting edge. Later changes have no effect.
- Backpressure: out_valid stays high indefinitely while out_ready=0. Result, zero and state are frozen.
- in_valid outside IDLE is ignored. The requester must hold in_valid until in_ready.
- Reset (asynchronous, any state including mid-SHIFT):
  - state=IDLE, in_ready=1.
  - out_valid=0, busy=0.
  - LogicUnitOut=0, zero=1, rem=0.
  - The in-flight op is discarded, and no out_valid is produced for it after reset release.
- out_valid and LogicUnitOut are driven from registers; no combinational path from inputs to outputs.

Test Plan:
- Logic ops (W=32, STEP=4):
  - X=0xF0F0_1234, Y=0x0FF0_FFFF.
  - AND → 0x00F0_1234.
  - XOR → 0xFF00_EDCB.
  - OR → 0xFFF0_FFFF.
  - Each has out_valid exactly 1 edge after accept, with out_ready=1.
- Shifts:
  - SRA X=0x8000_0000, Y=5 → 0xFC00_0000 at edge 3.
  - SRL same operands → 0x0400_0000.
  - SLL X=1, Y=31 → 0x8000_0000 at edge 9.
- Overrange and rotates:
  - SLL X=0xFFFF_FFFF, Y=40 → 0, zero=1, latency 9.
  - SRA X=0x8000_0001, Y=0xFFFF_FFFF → 0xFFFF_FFFF.
  - ROR X=0x1234_5678, Y=8 → 0x7812_3456.
  - ROL same operands, Y=40 → 0x3456_7812.
- Handshake:
  - Hold out_ready=0 for 10 cycles after out_valid: result, zero and in_ready=0 stay unchanged.
  - Change X/Y/LogicFunc during SHIFT: no effect on the result.
  - Assert in_valid continuously: back-to-back ops are accepted one cycle after each result handshake.
- Reset mid-op:
  - Assert rst_n=0 asynchronously (between edges) during SHIFT of SLL Y=20.
  - Outputs go to reset values immediately; no spurious out_valid after release.
  - Next op, AND X=3, Y=5 → 1.
- Parameter sweep:
  - WIDTH=8, STEP=1, SRA X=0x90, Y=3 → 0xF2, latency 4.
  - WIDTH=8, STEP=8, SLL X=0x90, Y=3 → 0x80, latency 2.
